// File: rtl/lsu_pkg.sv
// Shared load/store type codes, controller state encoding and type helpers for the LSU.
package lsu_pkg;

    localparam logic [3:0] LS_LB  = 4'b0000;
    localparam logic [3:0] LS_LH  = 4'b0010;
    localparam logic [3:0] LS_LW  = 4'b0100;
    localparam logic [3:0] LS_LBU = 4'b1000;
    localparam logic [3:0] LS_LHU = 4'b1010;
    localparam logic [3:0] LS_SB  = 4'b0001;
    localparam logic [3:0] LS_SH  = 4'b0011;
    localparam logic [3:0] LS_SW  = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_REQ2  = 3'd4,
        ST_WAIT2 = 3'd5
    } lsu_state_e;

    function automatic logic is_load(input logic [3:0] t);
        case (t)
            LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] t);
        case (t)
            LS_SB, LS_SH, LS_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] t, input logic [1:0] off);
        case (t)
            LS_LH, LS_LHU, LS_SH: is_misaligned = off[0];
            LS_LW, LS_SW:         is_misaligned = (off != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus with req/gnt/rvalid handshake between the LSU (master) and memory (slave).
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/data and load shift/extend.
// With LSU_MISALIGN_SPLIT_EN, also produces the second-word strobes/data and merges two read words.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  wr_type,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  we_lo,
    output logic [31:0] wdata_lo,
`ifdef LSU_MISALIGN_SPLIT_EN
    output logic [3:0]  we_hi,
    output logic [31:0] wdata_hi,
    input  logic [31:0] rd_hi,
`endif
    input  logic [3:0]  rd_type,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_lo,
    output logic [31:0] rd_ext
);
    logic [31:0] rep_b;
    logic [31:0] rep_h;
    logic [3:0]  mask;
    logic [31:0] sh;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]  wide_we;
    logic [63:0] wide_data;
    logic [63:0] cat;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rep_b[8*gi +: 8] = wr_data[7:0];
            assign rep_h[8*gi +: 8] = wr_data[8*(gi%2) +: 8];
        end
    endgenerate

    always_comb begin
        mask     = 4'b0000;
        wdata_lo = wr_data;
        case (wr_type)
            LS_SB: begin mask = 4'b0001; wdata_lo = rep_b;   end
            LS_SH: begin mask = 4'b0011; wdata_lo = rep_h;   end
            LS_SW: begin mask = 4'b1111; wdata_lo = wr_data; end
            default: ;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        // Spanning accesses use a plain shift so the spilled bytes land in the upper word.
        wide_we   = {4'b0000, mask} << wr_off;
        wide_data = {32'h0, wr_data} << {wr_off, 3'b000};
        we_lo     = wide_we[3:0];
        we_hi     = wide_we[7:4];
        wdata_hi  = wide_data[63:32];
        if (is_misaligned(wr_type, wr_off))
            wdata_lo = wide_data[31:0];
`else
        we_lo = mask << wr_off;
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign cat = {rd_hi, rd_lo};
    assign sh  = 32'(cat >> {rd_off, 3'b000});
`else
    assign sh  = rd_lo >> {rd_off, 3'b000};
`endif

    always_comb begin
        case (rd_type)
            LS_LB:   rd_ext = {{24{sh[7]}}, sh[7:0]};
            LS_LBU:  rd_ext = {24'h0, sh[7:0]};
            LS_LH:   rd_ext = {{16{sh[15]}}, sh[15:0]};
            LS_LHU:  rd_ext = {16'h0, sh[15:0]};
            LS_LW:   rd_ext = sh;
            default: rd_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer onto a single-port req/gnt/rvalid data memory.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two word accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_M,
    input  logic [3:0]        ls_type_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [DATA_W-1:0] wdata_M,
    output logic              stall_M,
    output logic              done_M,
    output logic [DATA_W-1:0] rdata_ext_M,
    output logic              misalign_M,
    lsu_mem_ctrl_if.master    mem
);
    lsu_state_e        state_reg;
    logic [3:0]        type_reg;
    logic [1:0]        off_reg;
    logic              done_reg;
    logic              misalign_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_we_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic [3:0]        we_lo;
    logic [31:0]       wdata_lo;
    logic [31:0]       rd_ext;
    logic [31:0]       rd_lo_sel;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]        we_hi;
    logic [31:0]       wdata_hi;
    logic [3:0]        we_hi_reg;
    logic [31:0]       wdata_hi_reg;
    logic [31:0]       lo_word_reg;
    logic              split_reg;

    assign rd_lo_sel = (state_reg == ST_WAIT2) ? lo_word_reg : mem.mem_rdata;
`else
    assign rd_lo_sel = mem.mem_rdata;
`endif

    lsu_lane_align u_align (
        .wr_type  (ls_type_M),
        .wr_off   (addr_M[1:0]),
        .wr_data  (wdata_M),
        .we_lo    (we_lo),
        .wdata_lo (wdata_lo),
`ifdef LSU_MISALIGN_SPLIT_EN
        .we_hi    (we_hi),
        .wdata_hi (wdata_hi),
        .rd_hi    (mem.mem_rdata),
`endif
        .rd_type  (type_reg),
        .rd_off   (off_reg),
        .rd_lo    (rd_lo_sel),
        .rd_ext   (rd_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            type_reg      <= 4'h0;
            off_reg       <= 2'b00;
            done_reg      <= 1'b0;
            misalign_reg  <= 1'b0;
            rdata_reg     <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 4'h0;
            mem_wdata_reg <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            we_hi_reg     <= 4'h0;
            wdata_hi_reg  <= 32'h0;
            lo_word_reg   <= 32'h0;
            split_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_M) begin
                        type_reg     <= ls_type_M;
                        off_reg      <= addr_M[1:0];
                        misalign_reg <= 1'b0;
                        rdata_reg    <= '0;
                        if (!(is_load(ls_type_M) || is_store(ls_type_M))) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
`ifndef LSU_MISALIGN_SPLIT_EN
                        else if (is_misaligned(ls_type_M, addr_M[1:0])) begin
                            state_reg    <= ST_DONE;
                            done_reg     <= 1'b1;
                            misalign_reg <= 1'b1;
                        end
`endif
                        else begin
                            state_reg     <= ST_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_addr_reg  <= {addr_M[ADDR_W-1:2], 2'b00};
                            mem_we_reg    <= we_lo;
                            mem_wdata_reg <= wdata_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
                            we_hi_reg     <= we_hi;
                            wdata_hi_reg  <= wdata_hi;
                            split_reg     <= is_misaligned(ls_type_M, addr_M[1:0]);
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        if (!is_store(type_reg)) begin
                            state_reg <= ST_WAIT;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        else if (split_reg) begin
                            // Second word issues right away; the request line stays high.
                            state_reg     <= ST_REQ2;
                            mem_req_reg   <= 1'b1;
                            mem_addr_reg  <= mem_addr_reg + ADDR_W'(4);
                            mem_we_reg    <= we_hi_reg;
                            mem_wdata_reg <= wdata_hi_reg;
                        end
`endif
                        else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (split_reg) begin
                            lo_word_reg  <= mem.mem_rdata;
                            state_reg    <= ST_REQ2;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= mem_addr_reg + ADDR_W'(4);
                            mem_we_reg   <= we_hi_reg;
                        end else begin
                            rdata_reg <= rd_ext;
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
`else
                        rdata_reg <= rd_ext;
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
`endif
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_REQ2: begin
                    if (mem.mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        if (is_store(type_reg)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT2;
                        end
                    end
                end
                ST_WAIT2: begin
                    if (mem.mem_rvalid) begin
                        rdata_reg <= rd_ext;
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign stall_M       = req_M & (state_reg != ST_DONE);
    assign done_M        = done_reg;
    assign misalign_M    = misalign_reg;
    assign rdata_ext_M   = rdata_reg;
    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, reset corner case, random traffic vs byte-level model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_M;
    logic [3:0]  ls_type_M;
    logic [31:0] addr_M;
    logic [31:0] wdata_M;
    logic        stall_M;
    logic        done_M;
    logic [31:0] rdata_ext_M;
    logic        misalign_M;

    lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif();

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_M       (req_M),
        .ls_type_M   (ls_type_M),
        .addr_M      (addr_M),
        .wdata_M     (wdata_M),
        .stall_M     (stall_M),
        .done_M      (done_M),
        .rdata_ext_M (rdata_ext_M),
        .misalign_M  (misalign_M),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] bus_ram [1024];
    logic [7:0] ref_ram [1024];

    typedef struct {
        logic [3:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gd;
        int          rv;
        logic [31:0] e_rd;
        logic        e_mis;
        int          e_n;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        int          e_done;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bus_word(input int a);
        return {bus_ram[a+3], bus_ram[a+2], bus_ram[a+1], bus_ram[a]};
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_ram[a+3], ref_ram[a+2], ref_ram[a+1], ref_ram[a]};
    endfunction

    task automatic preload(input int base, input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 4; i++) begin
            bus_ram[base+i]   = w0[8*i +: 8];
            ref_ram[base+i]   = w0[8*i +: 8];
            bus_ram[base+4+i] = w1[8*i +: 8];
            ref_ram[base+4+i] = w1[8*i +: 8];
        end
    endtask

    // Byte-level reference: what an access means, independent of how lanes are steered.
    task automatic model(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rv, output int e_done, output logic [31:0] e_rd,
                         output logic e_mis, output int e_n);
        int          sz;
        bit          valid;
        bit          load;
        bit          mis;
        logic [31:0] v;
        int          base;
        valid = (t == LS_LB || t == LS_LH || t == LS_LW || t == LS_LBU || t == LS_LHU ||
                 t == LS_SB || t == LS_SH || t == LS_SW);
        load  = 1'b0;
        e_rd  = 32'h0;
        e_mis = 1'b0;
        e_n   = 0;
        base  = int'(a[9:0]);
        if (valid) begin
            load = !t[0];
            sz   = (t[2:1] == 2'd0) ? 1 : (t[2:1] == 2'd1) ? 2 : 4;
            mis  = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
            e_n = mis ? 2 : 1;
`else
            if (mis) e_mis = 1'b1;
            else     e_n   = 1;
`endif
            if (e_n > 0) begin
                if (load) begin
                    v = 32'h0;
                    for (int i = 0; i < sz; i++) v |= 32'(ref_ram[base+i]) << (8*i);
                    if (!t[3] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8*sz);
                    e_rd = v;
                end else begin
                    for (int i = 0; i < sz; i++) ref_ram[base+i] = 8'(wd >> (8*i));
                end
            end
        end
        e_done = 1 + e_n * (1 + gd + (load ? rv : 0));
    endtask

    // Drives one MEM-stage request and plays the memory slave until done_M or a cycle budget.
    task automatic run_txn(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rv, output int done_cyc, output logic [31:0] rd,
                           output logic mis, output int nacc, output logic [31:0] f_addr,
                           output logic [3:0] f_we, output logic [31:0] f_wdata,
                           output logic stall_ok, output logic hold_ok);
        int          req_cnt;
        bit          pend;
        bit          waiting;
        int          due;
        logic [31:0] pword;
        int          wa;
        done_cyc = -1; rd = 32'h0; mis = 1'b0; nacc = 0;
        f_addr = 32'h0; f_we = 4'h0; f_wdata = 32'h0;
        stall_ok = 1'b1; hold_ok = 1'b1;
        req_cnt = 0; pend = 1'b0; waiting = 1'b0; due = 0; pword = 32'h0;
        req_M = 1'b1; ls_type_M = t; addr_M = a; wdata_M = wd;
        #1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = $urandom;
            if (done_M === 1'b1) begin
                done_cyc = cyc; rd = rdata_ext_M; mis = misalign_M;
                if (stall_M !== 1'b0) stall_ok = 1'b0;
            end else if (stall_M !== 1'b1) begin
                stall_ok = 1'b0;
            end
            if (pend && cyc == due) begin
                mif.mem_rvalid = 1'b1; mif.mem_rdata = pword; pend = 1'b0;
            end
            if (mif.mem_req === 1'b1) begin
                if (req_cnt == gd) begin
                    mif.mem_gnt = 1'b1;
                    nacc++;
                    if (nacc == 1) begin
                        f_addr = mif.mem_addr; f_we = mif.mem_we; f_wdata = mif.mem_wdata;
                    end
                    wa = int'(mif.mem_addr[9:0]);
                    if (t[0]) begin
                        for (int b = 0; b < 4; b++)
                            if (mif.mem_we[b]) bus_ram[wa+b] = mif.mem_wdata[8*b +: 8];
                    end else begin
                        pend = 1'b1; due = cyc + rv; pword = bus_word(wa);
                    end
                    req_cnt = 0; waiting = 1'b0;
                end else begin
                    req_cnt++; waiting = 1'b1;
                end
            end else if (waiting) begin
                hold_ok = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
        end
        req_M = 1'b0; mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
    endtask

    initial begin
        int          dc, n, e_done, e_n, gap, gd, rv;
        logic [31:0] rd, fa, fwd, e_rd, a, wd;
        logic [3:0]  fwe, t;
        logic        mis, sok, hok, e_mis;
        logic [3:0]  types [10];

        types = '{LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU, LS_SB, LS_SH, LS_SW, 4'b0110, 4'b1111};
        for (int i = 0; i < 1024; i++) begin
            bus_ram[i] = 8'($urandom);
            ref_ram[i] = bus_ram[i];
        end

        //          t       a         wd            w0            w1            gd rv e_rd          mis n  e_addr    we    e_wdata       done
        vecs[0]  = '{LS_SW,  32'h100, 32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 32'h0,        0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 2};
        vecs[1]  = '{LS_SB,  32'h203, 32'h000000A5, 32'h0,        32'h0,        3, 1, 32'h0,        0, 1, 32'h200, 4'h8, 32'hA5A5A5A5, 5};
        vecs[2]  = '{LS_LB,  32'h102, 32'h0,        32'h0080FF00, 32'h0,        0, 1, 32'hFFFFFF80, 0, 1, 32'h100, 4'h0, 32'h0,        3};
        vecs[3]  = '{LS_LBU, 32'h102, 32'h0,        32'h0080FF00, 32'h0,        0, 1, 32'h00000080, 0, 1, 32'h100, 4'h0, 32'h0,        3};
        vecs[4]  = '{LS_LH,  32'h102, 32'h0,        32'h80010000, 32'h0,        0, 1, 32'hFFFF8001, 0, 1, 32'h100, 4'h0, 32'h0,        3};
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs[5]  = '{LS_LW,  32'h101, 32'h0,        32'h44332211, 32'h88776655, 0, 1, 32'h55443322, 0, 2, 32'h100, 4'h0, 32'h0,        5};
        vecs[11] = '{LS_SH,  32'h203, 32'h0000BEEF, 32'h0,        32'h0,        0, 1, 32'h0,        0, 2, 32'h200, 4'h8, 32'hEF000000, 3};
`else
        vecs[5]  = '{LS_LW,  32'h101, 32'h0,        32'h44332211, 32'h88776655, 0, 1, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1};
        vecs[11] = '{LS_SH,  32'h203, 32'h0000BEEF, 32'h0,        32'h0,        0, 1, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1};
`endif
        vecs[6]  = '{LS_SH,  32'h102, 32'h00001234, 32'h0,        32'h0,        1, 1, 32'h0,        0, 1, 32'h100, 4'hC, 32'h12341234, 3};
        vecs[7]  = '{LS_LHU, 32'h100, 32'h0,        32'h1234F00D, 32'h0,        1, 2, 32'h0000F00D, 0, 1, 32'h100, 4'h0, 32'h0,        5};
        vecs[8]  = '{4'hF,   32'h100, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        1};
        vecs[9]  = '{LS_SB,  32'h101, 32'hFFFFFF5A, 32'h0,        32'h0,        0, 1, 32'h0,        0, 1, 32'h100, 4'h2, 32'h5A5A5A5A, 2};
        vecs[10] = '{LS_LW,  32'h104, 32'h0,        32'hCAFEF00D, 32'h0,        2, 3, 32'hCAFEF00D, 0, 1, 32'h104, 4'h0, 32'h0,        7};
        vecs[12] = '{LS_LB,  32'h103, 32'h0,        32'h7F000000, 32'h0,        0, 1, 32'h0000007F, 0, 1, 32'h100, 4'h0, 32'h0,        3};

        rst = 1'b1; req_M = 1'b0; ls_type_M = 4'h0; addr_M = 32'h0; wdata_M = 32'h0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall",    32'(stall_M),    32'h0);
        chk("rst_done",     32'(done_M),     32'h0);
        chk("rst_misalign", 32'(misalign_M), 32'h0);
        chk("rst_rdata",    rdata_ext_M,     32'h0);
        chk("rst_mem_req",  32'(mif.mem_req), 32'h0);
        chk("rst_mem_we",   32'(mif.mem_we),  32'h0);
        chk("rst_mem_addr", mif.mem_addr,    32'h0);
        chk("rst_mem_wdata", mif.mem_wdata,  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 13; v++) begin
            preload(int'(vecs[v].a[9:0]) & ~3, vecs[v].w0, vecs[v].w1);
            model(vecs[v].t, vecs[v].a, vecs[v].wd, vecs[v].gd, vecs[v].rv, e_done, e_rd, e_mis, e_n);
            run_txn(vecs[v].t, vecs[v].a, vecs[v].wd, vecs[v].gd, vecs[v].rv,
                    dc, rd, mis, n, fa, fwe, fwd, sok, hok);
            $display("vec %0d type=%b addr=%h done@%0d rdata=%h misalign=%0d accesses=%0d",
                     v, vecs[v].t, vecs[v].a, dc, rd, mis, n);
            chk($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'(vecs[v].e_done));
            chk($sformatf("vec%0d_misalign", v), 32'(mis), 32'(vecs[v].e_mis));
            chk($sformatf("vec%0d_accesses", v), 32'(n), 32'(vecs[v].e_n));
            chk($sformatf("vec%0d_stall", v), 32'(sok), 32'h1);
            chk($sformatf("vec%0d_req_hold", v), 32'(hok), 32'h1);
            if (!vecs[v].t[0] || vecs[v].e_n == 0)
                chk($sformatf("vec%0d_rdata", v), rd, vecs[v].e_rd);
            if (vecs[v].e_n > 0) begin
                chk($sformatf("vec%0d_mem_addr", v), fa, vecs[v].e_addr);
                chk($sformatf("vec%0d_mem_we", v), 32'(fwe), 32'(vecs[v].e_we));
                if (vecs[v].t[0])
                    chk($sformatf("vec%0d_mem_wdata", v), fwd, vecs[v].e_wdata);
            end
        end

        // Reset while waiting for load data; the rvalid that follows must be ignored.
        preload(32'h100, 32'h11223344, 32'h0);
        req_M = 1'b1; ls_type_M = LS_LW; addr_M = 32'h100; wdata_M = 32'h0;
        @(posedge clk); #1;
        chk("rstw_req_issued", 32'(mif.mem_req), 32'h1);
        mif.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mif.mem_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_M = 1'b0;
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hBADC0DE5;
        #1;
        chk("rstw_done_after_rst", 32'(done_M), 32'h0);
        chk("rstw_mem_req_dropped", 32'(mif.mem_req), 32'h0);
        chk("rstw_stall_follows_req0", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        mif.mem_rvalid = 1'b0;
        chk("rstw_done_stale_rvalid", 32'(done_M), 32'h0);
        chk("rstw_rdata_cleared", rdata_ext_M, 32'h0);
        req_M = 1'b1; ls_type_M = LS_LW;
        #1;
        chk("rstw_stall_follows_req1", 32'(stall_M), 32'h1);
        model(LS_LW, 32'h100, 32'h0, 0, 1, e_done, e_rd, e_mis, e_n);
        run_txn(LS_LW, 32'h100, 32'h0, 0, 1, dc, rd, mis, n, fa, fwe, fwd, sok, hok);
        $display("post-reset LW addr=00000100 done@%0d rdata=%h", dc, rd);
        chk("rstw_recover_done", 32'(dc), 32'(e_done));
        chk("rstw_recover_rdata", rd, e_rd);

        for (int k = 0; k < 250; k++) begin
            t  = ($urandom_range(0, 15) == 0) ? types[$urandom_range(8, 9)] : types[$urandom_range(0, 7)];
            a  = 32'($urandom_range(0, 1015));
            wd = $urandom;
            gd = $urandom_range(0, 3);
            rv = $urandom_range(1, 3);
            model(t, a, wd, gd, rv, e_done, e_rd, e_mis, e_n);
            run_txn(t, a, wd, gd, rv, dc, rd, mis, n, fa, fwe, fwd, sok, hok);
            $display("rnd %0d type=%b addr=%h wdata=%h done@%0d rdata=%h misalign=%0d",
                     k, t, a, wd, dc, rd, mis);
            chk($sformatf("rnd%0d_done_cycle", k), 32'(dc), 32'(e_done));
            chk($sformatf("rnd%0d_misalign", k), 32'(mis), 32'(e_mis));
            chk($sformatf("rnd%0d_accesses", k), 32'(n), 32'(e_n));
            chk($sformatf("rnd%0d_stall", k), 32'(sok), 32'h1);
            chk($sformatf("rnd%0d_req_hold", k), 32'(hok), 32'h1);
            if (!t[0] || e_n == 0) begin
                chk($sformatf("rnd%0d_rdata", k), rd, e_rd);
            end else begin
                chk($sformatf("rnd%0d_mem_lo", k), bus_word(int'(a[9:0]) & ~3), ref_word(int'(a[9:0]) & ~3));
                chk($sformatf("rnd%0d_mem_hi", k), bus_word((int'(a[9:0]) & ~3) + 4), ref_word((int'(a[9:0]) & ~3) + 4));
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mif.mem_rvalid = 1'b1; mif.mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                mif.mem_rvalid = 1'b0;
            end
            if (gap > 0) begin
                chk($sformatf("rnd%0d_idle_done", k), 32'(done_M), 32'h0);
                chk($sformatf("rnd%0d_idle_req", k), 32'(mif.mem_req), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
